// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed 4-digit seven-segment scan driver for a common-anode display.
// Takes a packed BCD word and scans it onto the display. It also handles:
//   - frame-synchronous capture, so a frame never mixes old and new digits
//   - leading-zero blanking
//   - a dash for nibbles A-F
//   - whole-display blink
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   bcd_in     packed BCD, digit 3 = [15:12] ... digit 0 = [3:0]
//   dp_in      decimal point per digit, 1 = lit
//   load       capture bcd_in/dp_in (shown from the next frame boundary)
//   blank_lz   enable leading-zero blanking
//   blink_en   enable whole-display blink
//   seg_n      segments {g,f,e,d,c,b,a}, active-low
//   dp_n       decimal point, active-low
//   an_n       digit anodes, active-low, bit i = digit i
//   frame_done one-cycle pulse at each frame boundary
module seg7_scan_driver #(
  parameter int CLK_DIV      = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  input  logic        blink_en,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_done
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

  // {bcd[15:0], dp[3:0]}
  logic [19:0]   pend_q, pend_d;
  logic [19:0]   disp_q, disp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic          dp_n_q, dp_n_d;
  logic [3:0]    an_n_q, an_n_d;
  logic          fd_q, fd_d;

  logic       tick, boundary, blank;
  logic [3:0] nib;
  logic       d3z, d2z, d1z;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'd0:    dec7 = 7'h40;
      4'd1:    dec7 = 7'h79;
      4'd2:    dec7 = 7'h24;
      4'd3:    dec7 = 7'h30;
      4'd4:    dec7 = 7'h19;
      4'd5:    dec7 = 7'h12;
      4'd6:    dec7 = 7'h02;
      4'd7:    dec7 = 7'h78;
      4'd8:    dec7 = 7'h00;
      4'd9:    dec7 = 7'h10;
      default: dec7 = 7'h3F;  // non-BCD nibble: dash (g only)
    endcase
  endfunction

  always_comb begin
    tick     = (cnt_q == CNT_MAX);
    boundary = tick && (idx_q == 2'd3);

    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = tick ? idx_q + 2'd1 : idx_q;

    // A load on the boundary edge goes straight to the display so the newest value wins.
    pend_d = load ? {bcd_in, dp_in} : pend_q;
    disp_d = disp_q;
    if (boundary) disp_d = load ? {bcd_in, dp_in} : pend_q;

    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (!blink_en) begin
      bcnt_d  = '0;
      phase_d = 1'b1;
    end else if (boundary) begin
      if (bcnt_q == BLINK_MAX) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end

    case (idx_q)
      2'd0:    nib = disp_q[7:4];
      2'd1:    nib = disp_q[11:8];
      2'd2:    nib = disp_q[15:12];
      default: nib = disp_q[19:16];
    endcase

    d3z = (disp_q[19:16] == 4'd0);
    d2z = (disp_q[15:12] == 4'd0);
    d1z = (disp_q[11:8] == 4'd0);
    case (idx_q)
      2'd3:    blank = blank_lz && d3z;
      2'd2:    blank = blank_lz && d3z && d2z;
      2'd1:    blank = blank_lz && d3z && d2z && d1z;
      default: blank = 1'b0;
    endcase

    seg_n_d = blank ? 7'h7F : dec7(nib);
    dp_n_d  = ~disp_q[idx_q];
    // First cycle of each slot is dead time so the previous digit does not ghost.
    an_n_d  = ((cnt_q == '0) || !phase_q) ? 4'hF : ~(4'b0001 << idx_q);
    fd_d    = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      disp_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b1;
      seg_n_q <= 7'h7F;
      dp_n_q  <= 1'b1;
      an_n_q  <= 4'hF;
      fd_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      seg_n_q <= seg_n_d;
      dp_n_q  <= dp_n_d;
      an_n_q  <= an_n_d;
      fd_q    <= fd_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load, blank_lz, blink_en;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dpn;
  } exp_t;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        blz;
    logic [6:0]  s3, s2, s1, s0;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[9];

  seg7_scan_driver #(.CLK_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .blink_en(blink_en), .seg_n(seg_n), .dp_n(dp_n),
    .an_n(an_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got %0h expected %0h", name, got, exp);
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    logic [3:0] one;
    one = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      e.an  = ~(one << i);
      case (i)
        0:       e.seg = v.s0;
        1:       e.seg = v.s1;
        2:       e.seg = v.s2;
        default: e.seg = v.s3;
      endcase
      e.dpn = ~v.dp[i];
      sbq.push_back(e);
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 100);
    chk("frame_seen", {31'd0, frame_done}, 32'd1);
  endtask

  // Called at the negedge showing frame_done; checks the 16 cycles of the new frame.
  task automatic check_frame(input string tag);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      chk({tag, "_dead_an"}, {28'd0, an_n}, 32'hF);
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL %s_sb_empty got 0 entries expected >0", tag);
        return;
      end
      e = sbq[0];
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk({tag, "_an"},  {28'd0, an_n},  {28'd0, e.an});
        chk({tag, "_seg"}, {25'd0, seg_n}, {25'd0, e.seg});
        chk({tag, "_dp"},  {31'd0, dp_n},  {31'd0, e.dpn});
      end
      void'(sbq.pop_front());
    end
    chk({tag, "_period"}, {31'd0, frame_done}, 32'd1);
  endtask

  initial begin
    vec_t v;
    int   lit;
    bit   exp_on [6];

    vecs[0] = '{16'h1234, 4'b0000, 1'b0, 7'h79, 7'h24, 7'h30, 7'h19};
    vecs[1] = '{16'h0007, 4'b0001, 1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h78};
    vecs[2] = '{16'h0007, 4'b0000, 1'b0, 7'h40, 7'h40, 7'h40, 7'h78};
    vecs[3] = '{16'h0000, 4'b0000, 1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    vecs[4] = '{16'h00A5, 4'b0000, 1'b1, 7'h7F, 7'h7F, 7'h3F, 7'h12};
    vecs[5] = '{16'h5680, 4'b1010, 1'b1, 7'h12, 7'h02, 7'h00, 7'h40};
    vecs[6] = '{16'h0909, 4'b0100, 1'b1, 7'h7F, 7'h10, 7'h40, 7'h10};
    vecs[7] = '{16'hFB0E, 4'b1111, 1'b1, 7'h3F, 7'h3F, 7'h40, 7'h3F};
    vecs[8] = '{16'h0030, 4'b0000, 1'b1, 7'h7F, 7'h7F, 7'h30, 7'h40};
    exp_on = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0; bcd_in = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0; blink_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an",  {28'd0, an_n},       32'hF);
    chk("rst_seg", {25'd0, seg_n},      32'h7F);
    chk("rst_dp",  {31'd0, dp_n},       32'd1);
    chk("rst_fd",  {31'd0, frame_done}, 32'd0);

    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk("first_an",  {28'd0, an_n},  32'hF);
        chk("first_seg", {25'd0, seg_n}, 32'h40);
      end
      if (n == 2)  chk("first_lit_an", {28'd0, an_n}, 32'hE);
      if (n == 15) chk("first_fd_low", {31'd0, frame_done}, 32'd0);
      if (n == 16) chk("first_fd",     {31'd0, frame_done}, 32'd1);
    end

    foreach (vecs[k]) begin
      blank_lz = vecs[k].blz;
      bcd_in = vecs[k].bcd; dp_in = vecs[k].dp; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      push_exp(vecs[k]);
      wait_frame();
      check_frame($sformatf("vec%0d", k));
    end

    // Mid-frame load followed by a load on the boundary edge.
    blank_lz = 1'b0;
    bcd_in = 16'h1111; dp_in = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (14) @(negedge clk);
    chk("tear_pre_fd", {31'd0, frame_done}, 32'd0);
    bcd_in = 16'h2222; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("tear_boundary", {31'd0, frame_done}, 32'd1);
    v = '{16'h2222, 4'b0000, 1'b0, 7'h24, 7'h24, 7'h24, 7'h24};
    push_exp(v);
    check_frame("tear1");
    push_exp(v);
    check_frame("tear2");

    // Blink: two frames on/off per half-period.
    blink_en = 1'b1;
    wait_frame();
    for (int w = 0; w < 6; w++) begin
      lit = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (an_n != 4'hF) lit++;
      end
      chk($sformatf("blink_w%0d_lit", w), lit, exp_on[w] ? 32'd12 : 32'd0);
      chk($sformatf("blink_w%0d_fd", w), {31'd0, frame_done}, 32'd1);
    end
    @(negedge clk);
    blink_en = 1'b0;
    @(negedge clk);
    chk("unblink_still_off", {28'd0, an_n}, 32'hF);
    @(negedge clk);
    chk("unblink_resume", {28'd0, an_n}, 32'hE);

    // Reset in the middle of a frame discards both display and pending.
    bcd_in = 16'h9999; dp_in = 4'b1111; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    v = '{16'h9999, 4'b1111, 1'b0, 7'h10, 7'h10, 7'h10, 7'h10};
    push_exp(v);
    wait_frame();
    check_frame("pre_rst");
    repeat (5) @(negedge clk);
    bcd_in = 16'h5555; dp_in = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("pre_rst_an",  {28'd0, an_n},  32'hD);
    chk("pre_rst_seg", {25'd0, seg_n}, 32'h10);
    chk("pre_rst_dp",  {31'd0, dp_n},  32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_an",  {28'd0, an_n},       32'hF);
    chk("midrst_seg", {25'd0, seg_n},      32'h7F);
    chk("midrst_dp",  {31'd0, dp_n},       32'd1);
    chk("midrst_fd",  {31'd0, frame_done}, 32'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v = '{16'h0000, 4'b0000, 1'b0, 7'h40, 7'h40, 7'h40, 7'h40};
    push_exp(v);
    wait_frame();
    check_frame("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
